branch_resolve_unit: RTL and testbench

//  ID-stage consumer of the 18->32 sign-extended branch offset (imm16<<2).

---
 rtl/branch_resolve_if.sv | 32 +++
 rtl/branch_resolve_unit.sv | 114 +++++++++++
 tb/tb_branch_resolve_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Interface carrying the ID-stage branch operands into the branch resolve
// unit and its stall / redirect / status outputs back to the pipeline.
interface branch_resolve_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [2:0]        id_br_op;
   logic [ADDR_W-1:0] id_pc_plus4;
   logic [ADDR_W-1:0] id_offset_ext;
   logic [ADDR_W-1:0] id_rs_val;
   logic [ADDR_W-1:0] id_rt_val;
   logic              opnd_ready;
   logic              stall_out;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              resolved;
   logic              br_err;
   logic [CNT_W-1:0]  taken_cnt;

   // Pipeline side: drives the ID-stage instruction, consumes stall/redirect.
   modport master (
      output id_valid, id_br_op, id_pc_plus4, id_offset_ext, id_rs_val, id_rt_val, opnd_ready,
      input  stall_out, redirect_valid, redirect_pc, resolved, br_err, taken_cnt
   );

   // Branch resolve unit side.
   modport slave (
      input  id_valid, id_br_op, id_pc_plus4, id_offset_ext, id_rs_val, id_rt_val, opnd_ready,
      output stall_out, redirect_valid, redirect_pc, resolved, br_err, taken_cnt
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage MIPS conditional branch resolver. Evaluates beq/bne/bgez/bltz/
// bgtz/blez, computes pc_plus4 + offset, and issues a registered one-cycle
// PC redirect. Stalls IF/ID until forwarded operands are final. The cycle
// after a resolve is the delay slot; a branch seen there is flagged as an
// error and not evaluated.
module branch_resolve_unit #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input logic              clk,
   input logic              rst_n,
   branch_resolve_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT, REDIR, DSLOT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc4_lat;
   logic [ADDR_W-1:0] off_lat;
   logic [2:0]        op_lat;
   logic              redirect_valid_reg;
   logic [ADDR_W-1:0] redirect_pc_reg;
   logic              resolved_reg;
   logic              br_err_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic              is_br;
   logic              eval_now;
   logic [2:0]        eval_op;
   logic [ADDR_W-1:0] target;
   logic              rs_neg;
   logic              rs_zero;
   logic              taken;
   logic              stall;

   // Branch decode, condition evaluation, target adder and the stall request.
   // While waiting, the stalled instruction's op/pc/offset come from the
   // latches; rs/rt are always the live forwarded values.
   always_comb begin
      is_br    = bus.id_valid && (bus.id_br_op != 3'd0) && (bus.id_br_op != 3'd7);
      eval_now = ((state == IDLE) && is_br && bus.opnd_ready) ||
                 ((state == WAIT) && bus.opnd_ready);
      eval_op  = (state == WAIT) ? op_lat : bus.id_br_op;
      target   = (state == WAIT) ? (pc4_lat + off_lat) : (bus.id_pc_plus4 + bus.id_offset_ext);
      rs_neg   = bus.id_rs_val[ADDR_W-1];
      rs_zero  = (bus.id_rs_val == '0);
      taken    = 1'b0;
      case (eval_op)
         3'd1:    taken = (bus.id_rs_val == bus.id_rt_val);
         3'd2:    taken = (bus.id_rs_val != bus.id_rt_val);
         3'd3:    taken = !rs_neg;
         3'd4:    taken = rs_neg;
         3'd5:    taken = !rs_neg && !rs_zero;
         3'd6:    taken = rs_neg || rs_zero;
         default: taken = 1'b0;
      endcase
      // Gated by rst_n so the stall drops immediately while reset is held.
      stall = 1'b0;
      if (rst_n) begin
         if (state == IDLE)      stall = is_br && !bus.opnd_ready;
         else if (state == WAIT) stall = !bus.opnd_ready;
      end
   end

   // Resolve FSM with registered pulses, target register and saturating counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         pc4_lat            <= '0;
         off_lat            <= '0;
         op_lat             <= '0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
         resolved_reg       <= 1'b0;
         br_err_reg         <= 1'b0;
         cnt_reg            <= '0;
      end else begin
         redirect_valid_reg <= 1'b0;
         resolved_reg       <= 1'b0;
         br_err_reg         <= 1'b0;
         case (state)
            IDLE, WAIT: begin
               if (eval_now) begin
                  resolved_reg <= 1'b1;
                  if (taken) begin
                     redirect_valid_reg <= 1'b1;
                     redirect_pc_reg    <= target;
                     if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
                     state <= REDIR;
                  end else begin
                     state <= DSLOT;
                  end
               end else if ((state == IDLE) && is_br) begin
                  pc4_lat <= bus.id_pc_plus4;
                  off_lat <= bus.id_offset_ext;
                  op_lat  <= bus.id_br_op;
                  state   <= WAIT;
               end
            end
            default: begin
               // Delay-slot cycle: a branch here is illegal and never evaluated.
               br_err_reg <= is_br;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.stall_out      = stall;
   assign bus.redirect_valid = redirect_valid_reg;
   assign bus.redirect_pc    = redirect_pc_reg;
   assign bus.resolved       = resolved_reg;
   assign bus.br_err         = br_err_reg;
   assign bus.taken_cnt      = cnt_reg;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases followed by
// randomized branches compared against a behavioural model (signed integer
// compares, 64-bit modular target, clamped counter).
module tb_branch_resolve_unit;
   localparam int AW = 32;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
   branch_resolve_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          checks = 0;
   int          failures = 0;
   int          model_cnt = 0;
   logic [31:0] last_pc = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference branch condition from the ISA definition.
   function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      int s;
      s = rs;
      case (op)
         3'd1:    return rs == rt;
         3'd2:    return rs != rt;
         3'd3:    return s >= 0;
         3'd4:    return s < 0;
         3'd5:    return s > 0;
         3'd6:    return s <= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input logic [31:0] pc4, input logic [31:0] off);
      longint unsigned sum;
      sum = (longint'(pc4) + longint'(off)) % 64'h1_0000_0000;
      return sum[31:0];
   endfunction

   // One ID-stage transaction: present it, hold opnd_ready low for 'waits'
   // cycles, check the resolve outputs, then run the delay-slot cycle
   // (optionally with an illegal branch in it).
   task automatic branch(input logic [2:0] op, input logic [31:0] pc4, input logic [31:0] off,
                         input logic [31:0] rs, input logic [31:0] rt, input int waits, input bit dslot_br);
      bit          isb;
      bit          tk;
      logic [31:0] tgt;
      isb = (op >= 3'd1) && (op <= 3'd6);
      bus.id_valid = 1'b1;
      bus.id_br_op = op;
      bus.id_pc_plus4 = pc4;
      bus.id_offset_ext = off;
      bus.id_rs_val = rs;
      bus.id_rt_val = rt;
      bus.opnd_ready = (waits == 0);
      if (!isb) begin
         #1 chk("nb_stall", 32'(bus.stall_out), 32'd0);
         step();
         chk("nb_resolved", 32'(bus.resolved), 32'd0);
         chk("nb_redirect", 32'(bus.redirect_valid), 32'd0);
         bus.id_valid = 1'b0;
         $display("txn op=%0d non-branch", op);
         return;
      end
      for (int i = 0; i < waits; i++) begin
         #1 chk("stall_hi", 32'(bus.stall_out), 32'd1);
         step();
         // pc/offset changes during the stall must not affect the target
         bus.id_pc_plus4 = $urandom;
         bus.id_offset_ext = $urandom;
      end
      bus.opnd_ready = 1'b1;
      #1 chk("stall_lo", 32'(bus.stall_out), 32'd0);
      step();
      tk = ref_taken(op, rs, rt);
      tgt = ref_target(pc4, off);
      if (tk) begin
         if (model_cnt < (1 << CW) - 1) model_cnt++;
         last_pc = tgt;
      end
      chk("resolved", 32'(bus.resolved), 32'd1);
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(tk));
      chk("redirect_pc", bus.redirect_pc, last_pc);
      chk("taken_cnt", 32'(bus.taken_cnt), 32'(model_cnt));
      if (dslot_br) begin
         bus.id_br_op = 3'd1;
         bus.id_rs_val = '0;
         bus.id_rt_val = '0;
      end else begin
         bus.id_valid = 1'b0;
      end
      #1 chk("dslot_stall", 32'(bus.stall_out), 32'd0);
      step();
      chk("dslot_br_err", 32'(bus.br_err), 32'(dslot_br));
      chk("dslot_redirect", 32'(bus.redirect_valid), 32'd0);
      chk("dslot_resolved", 32'(bus.resolved), 32'd0);
      chk("dslot_pc_hold", bus.redirect_pc, last_pc);
      bus.id_valid = 1'b0;
      if (dslot_br) begin
         step();
         chk("br_err_once", 32'(bus.br_err), 32'd0);
         chk("no_second_redirect", 32'(bus.redirect_valid), 32'd0);
      end
      $display("txn op=%0d pc4=%08h off=%08h rs=%08h rt=%08h waits=%0d taken=%0d pc=%08h cnt=%0d",
               op, pc4, off, rs, rt, waits, tk, last_pc, model_cnt);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
      chk({tag, "_rv"}, 32'(bus.redirect_valid), 32'd0);
      chk({tag, "_pc"}, bus.redirect_pc, 32'd0);
      chk({tag, "_res"}, 32'(bus.resolved), 32'd0);
      chk({tag, "_err"}, 32'(bus.br_err), 32'd0);
      chk({tag, "_cnt"}, 32'(bus.taken_cnt), 32'd0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      // Reset with a pending branch on the inputs: stall must stay low.
      bus.id_valid = 1'b1;
      bus.id_br_op = 3'd1;
      bus.id_pc_plus4 = '0;
      bus.id_offset_ext = '0;
      bus.id_rs_val = '0;
      bus.id_rt_val = '0;
      bus.opnd_ready = 1'b0;
      #2 check_all_zero("reset");
      bus.id_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      branch(3'd1, 32'h100, 32'h10, 32'd5, 32'd5, 0, 1'b0);                // beq taken -> 0x110
      branch(3'd2, 32'h200, 32'h20, 32'd7, 32'd7, 0, 1'b0);                // bne not taken
      branch(3'd3, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);        // bgez stalled, not taken
      branch(3'd1, 32'hFFFF_FFFC, 32'h8, 32'd1, 32'd1, 0, 1'b0);           // wrap -> 0x4
      branch(3'd1, 32'h100, 32'hFFFF_FFF0, 32'd3, 32'd3, 1, 1'b0);         // negative offset -> 0xF0
      branch(3'd5, 32'h400, 32'h4, 32'd0, 32'd0, 0, 1'b0);                 // bgtz zero -> not taken
      branch(3'd6, 32'h400, 32'h4, 32'd0, 32'd0, 0, 1'b0);                 // blez zero -> taken
      branch(3'd4, 32'h500, 32'h8, 32'h8000_0000, 32'd0, 0, 1'b0);         // bltz min int -> taken
      branch(3'd1, 32'h600, 32'h40, 32'd9, 32'd9, 0, 1'b1);                // branch in delay slot
      branch(3'd7, 32'h700, 32'h40, 32'd9, 32'd9, 0, 1'b0);                // reserved op

      // Reset asserted while waiting for operands.
      bus.id_valid = 1'b1;
      bus.id_br_op = 3'd1;
      bus.opnd_ready = 1'b0;
      #1 chk("pre_wait_stall", 32'(bus.stall_out), 32'd1);
      step();
      rst_n = 1'b0;
      #1 check_all_zero("rst_wait");
      bus.id_valid = 1'b0;
      model_cnt = 0;
      last_pc = '0;
      step();
      rst_n = 1'b1;
      step();

      // Randomized branches against the reference model.
      for (int n = 0; n < 150; n++) begin
         op = 3'($urandom_range(0, 7));
         rs = $urandom;
         rt = $urandom;
         case ($urandom_range(0, 3))
            0: rt = rs;
            1: rs = '0;
            2: rs = {1'b1, rs[30:0]};
            default: ;
         endcase
         branch(op, $urandom, $urandom, rs, rt, $urandom_range(0, 2), 1'b0);
      end

      // Counter saturation from a fresh reset.
      rst_n = 1'b0;
      #1 chk("sat_rst_cnt", 32'(bus.taken_cnt), 32'd0);
      model_cnt = 0;
      last_pc = '0;
      step();
      rst_n = 1'b1;
      step();
      for (int n = 0; n < 255; n++) branch(3'd1, 32'h1000, 32'(n * 4), 32'd1, 32'd1, 0, 1'b0);
      chk("sat_255", 32'(bus.taken_cnt), 32'hFF);
      branch(3'd1, 32'h2000, 32'h4, 32'd1, 32'd1, 0, 1'b0);
      chk("sat_hold", 32'(bus.taken_cnt), 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
